// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg: shared scoreboard entry, FSM state and forwarding-select types
package arm_pipe_pkg;
  localparam int SB_REG_W = 4;
  typedef struct packed {
    logic                wb_en;
    logic                mem_r_en;
    logic [SB_REG_W-1:0] dest;
  } sb_entry_t;
  localparam sb_entry_t SB_BUBBLE = '0;
  typedef enum logic { RUN, FLUSH } pipe_state_t;
  typedef enum logic [1:0] { FWD_RF = 2'd0, FWD_EXE_MEM = 2'd1, FWD_MEM_WB = 2'd2 } fwd_sel_t;
  function automatic fwd_sel_t fwd_pick(input logic m_exe, input logic m_mem);
    return m_exe ? FWD_EXE_MEM : (m_mem ? FWD_MEM_WB : FWD_RF);
  endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one scoreboard slot against the decode-stage sources.
// HAZARD_FORWARDING_EN exposes the per-source matches for forwarding selects.
module hazard_match
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = SB_REG_W
) (
  input  sb_entry_t        i_slot,
  input  logic [REG_W-1:0] i_src1,
  input  logic [REG_W-1:0] i_src2,
  input  logic             i_two_src,
  input  logic             i_id_valid,
  input  logic             i_load_only,
`ifdef HAZARD_FORWARDING_EN
  output logic [1:0]       o_m,
`endif
  output logic             o_raw
);
  logic       w_live;
  logic [1:0] w_m;
  assign w_live = i_slot.wb_en & i_id_valid;
  assign w_m    = {w_live & i_two_src & (i_slot.dest == i_src2), w_live & (i_slot.dest == i_src1)};
  // when only loads can stall, an ALU producer is covered by forwarding
  assign o_raw  = |w_m & (~i_load_only | i_slot.mem_r_en);
`ifdef HAZARD_FORWARDING_EN
  assign o_m = w_m;
`endif
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: RAW scoreboard, branch flush and memory-wait freeze sequencing.
// HAZARD_FORWARDING_EN: stall only on load-use and drive fwd_sel1/fwd_sel2.
module hazard_stall_controller
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = SB_REG_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             b_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             hazard,
  output logic             freeze,
  output logic             flush,
`ifdef HAZARD_FORWARDING_EN
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
`endif
  output logic [CNT_W-1:0] stall_cnt
);
`ifdef HAZARD_FORWARDING_EN
  localparam logic LOAD_ONLY = 1'b1;
  logic [1:0] w_exe_m, w_mem_m;
`else
  localparam logic LOAD_ONLY = 1'b0;
`endif
  sb_entry_t        r_exe, r_mem, w_id_entry;
  pipe_state_t      r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic             w_exe_raw, w_mem_raw, w_raw;

  hazard_match #(.REG_W(REG_W)) u_exe_match (
    .i_slot(r_exe), .i_src1(src1), .i_src2(src2), .i_two_src(two_src),
    .i_id_valid(id_valid), .i_load_only(LOAD_ONLY),
`ifdef HAZARD_FORWARDING_EN
    .o_m(w_exe_m),
`endif
    .o_raw(w_exe_raw)
  );

  hazard_match #(.REG_W(REG_W)) u_mem_match (
    .i_slot(r_mem), .i_src1(src1), .i_src2(src2), .i_two_src(two_src),
    .i_id_valid(id_valid), .i_load_only(LOAD_ONLY),
`ifdef HAZARD_FORWARDING_EN
    .o_m(w_mem_m),
`endif
    .o_raw(w_mem_raw)
  );

`ifdef HAZARD_FORWARDING_EN
  assign w_raw    = w_exe_raw;
  assign fwd_sel1 = fwd_pick(w_exe_m[0], w_mem_m[0]);
  assign fwd_sel2 = fwd_pick(w_exe_m[1], w_mem_m[1]);
`else
  assign w_raw = w_exe_raw | w_mem_raw;
`endif

  assign freeze    = mem_req & ~mem_ready;
  // a flush pending during a memory wait stays in FLUSH until the wait ends
  assign flush     = (r_state == FLUSH) & ~freeze;
  assign hazard    = w_raw & ~flush & ~freeze;
  assign stall_cnt = r_cnt;

  always_comb begin
    w_id_entry = '{wb_en: id_wb_en & id_valid, mem_r_en: id_mem_r_en & id_valid, dest: id_dest};
    w_state_nx = (r_state == RUN) ? ((b_taken & ~freeze) ? FLUSH : RUN) : (freeze ? FLUSH : RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_exe   <= SB_BUBBLE;
      r_mem   <= SB_BUBBLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (!freeze) begin
        r_mem <= r_exe;
        r_exe <= (hazard | b_taken) ? SB_BUBBLE : w_id_entry;
      end
      if (hazard && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: scoreboard-driven bench for the default (no forwarding) build.
module tb_hazard_stall_controller;
  logic       clk = 1'b0;
  logic       rst_n, id_valid, two_src, id_wb_en, id_mem_r_en, b_taken, mem_req, mem_ready;
  logic [3:0] src1, src2, id_dest;
  logic       hazard, freeze, flush;
  logic [7:0] stall_cnt;
`ifdef HAZARD_FORWARDING_EN
  logic [1:0] fwd_sel1, fwd_sel2;
`endif

  typedef struct {
    logic v; logic [3:0] s1, s2; logic two, wb, ld; logic [3:0] d;
    logic bt, mq, mr, hz, fr, fl; string name;
  } stim_t;
  typedef struct { logic hz, fr, fl; string name; } exp_t;

  stim_t stim_q[$];
  exp_t  sb_q[$];
  int    checks = 0;
  int    failures = 0;
  int    exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.REG_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst_n), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .b_taken(b_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .hazard(hazard), .freeze(freeze), .flush(flush),
`ifdef HAZARD_FORWARDING_EN
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
`endif
    .stall_cnt(stall_cnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, time=%0t", $time);
    $fatal(1);
  end

  task automatic add(input string name, input logic v, input logic [3:0] s1, input logic [3:0] s2,
                     input logic two, input logic wb, input logic ld, input logic [3:0] d,
                     input logic bt, input logic mq, input logic mr,
                     input logic hz, input logic fr, input logic fl);
    stim_t s;
    s.name = name; s.v = v; s.s1 = s1; s.s2 = s2; s.two = two; s.wb = wb; s.ld = ld; s.d = d;
    s.bt = bt; s.mq = mq; s.mr = mr; s.hz = hz; s.fr = fr; s.fl = fl;
    stim_q.push_back(s);
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    id_valid = s.v; src1 = s.s1; src2 = s.s2; two_src = s.two; id_wb_en = s.wb;
    id_mem_r_en = s.ld; id_dest = s.d; b_taken = s.bt; mem_req = s.mq; mem_ready = s.mr;
    e.hz = s.hz; e.fr = s.fr; e.fl = s.fl; e.name = s.name;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply('{v: 1'b1, s1: 4'd1, s2: 4'd1, two: 1'b1, wb: 1'b1, ld: 1'b0, d: 4'd1,
            bt: 1'b0, mq: 1'b0, mr: 1'b0, hz: 1'b0, fr: 1'b0, fl: 1'b0, name: "reset"});
    void'(sb_q.pop_front());
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    checks++; if (freeze !== 1'b0) begin failures++; $display("FAIL reset_freeze: got %b want 0", freeze); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b want 0", flush); end
    checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_raw_stall();
    exp_t e;
    add("issue_add_r1", 1, 2, 3, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add("dep_in_exe",   1, 1, 3, 1, 1, 0, 2, 0, 0, 0, 1, 0, 0);
    add("dep_in_mem",   1, 1, 3, 1, 1, 0, 2, 0, 0, 0, 1, 0, 0);
    add("dep_issue",    1, 1, 3, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0);
    add("r2_in_exe",    1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("r2_in_mem",    1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("r2_clear",     1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({hazard, freeze, flush, stall_cnt} !== {e.hz, e.fr, e.fl, 8'(exp_cnt)}) begin
        failures++;
        $display("FAIL raw_stall/%s: got hz=%b fr=%b fl=%b cnt=%0d want hz=%b fr=%b fl=%b cnt=%0d",
                 e.name, hazard, freeze, flush, stall_cnt, e.hz, e.fr, e.fl, exp_cnt);
      end
      if (e.hz && exp_cnt < 255) exp_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_two_src_r15();
    exp_t e;
    add("issue_r15",   1, 0, 0, 0, 1, 0, 15, 0, 0, 0, 0, 0, 0);
    add("src2_unread", 1, 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("id_invalid",  0, 15, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("issue_r15b",  1, 0, 0, 0, 1, 0, 15, 0, 0, 0, 0, 0, 0);
    add("r15_exe",     1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("r15_mem",     1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("r15_clear",   1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({hazard, freeze, flush, stall_cnt} !== {e.hz, e.fr, e.fl, 8'(exp_cnt)}) begin
        failures++;
        $display("FAIL two_src/%s: got hz=%b fr=%b fl=%b cnt=%0d want hz=%b fr=%b fl=%b cnt=%0d",
                 e.name, hazard, freeze, flush, stall_cnt, e.hz, e.fr, e.fl, exp_cnt);
      end
      if (e.hz && exp_cnt < 255) exp_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch_flush();
    exp_t e;
    add("issue_r3",     1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    add("branch_taken", 1, 0, 0, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0);
    add("flush_cycle",  1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("r4_bubbled",   1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({hazard, freeze, flush, stall_cnt} !== {e.hz, e.fr, e.fl, 8'(exp_cnt)}) begin
        failures++;
        $display("FAIL branch/%s: got hz=%b fr=%b fl=%b cnt=%0d want hz=%b fr=%b fl=%b cnt=%0d",
                 e.name, hazard, freeze, flush, stall_cnt, e.hz, e.fr, e.fl, exp_cnt);
      end
      if (e.hz && exp_cnt < 255) exp_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    add("issue_r6", 1, 0, 0, 0, 1, 0, 6, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("frozen", 1, 6, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    add("release",  1, 6, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
    add("flush",    1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({hazard, freeze, flush, stall_cnt} !== {e.hz, e.fr, e.fl, 8'(exp_cnt)}) begin
        failures++;
        $display("FAIL freeze/%s: got hz=%b fr=%b fl=%b cnt=%0d want hz=%b fr=%b fl=%b cnt=%0d",
                 e.name, hazard, freeze, flush, stall_cnt, e.hz, e.fr, e.fl, exp_cnt);
      end
      if (e.hz && exp_cnt < 255) exp_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_saturation_reset();
    exp_t e;
    for (int i = 0; i < 392; i++) add("sat", 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, logic'(i % 3 != 0), 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({hazard, freeze, flush, stall_cnt} !== {e.hz, e.fr, e.fl, 8'(exp_cnt)}) begin
        failures++;
        $display("FAIL saturation/%s: got hz=%b fr=%b fl=%b cnt=%0d want hz=%b fr=%b fl=%b cnt=%0d",
                 e.name, hazard, freeze, flush, stall_cnt, e.hz, e.fr, e.fl, exp_cnt);
      end
      if (e.hz && exp_cnt < 255) exp_cnt++;
      @(posedge clk);
      #1;
    end
    checks++; if (stall_cnt !== 8'd255) begin failures++; $display("FAIL sat_cnt: got %0d want 255", stall_cnt); end
    #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL mid_stall: got hazard=%b want 1", hazard); end
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL rst_mid_hazard: got %b want 0", hazard); end
    checks++; if (freeze !== 1'b0) begin failures++; $display("FAIL rst_mid_freeze: got %b want 0", freeze); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_mid_flush: got %b want 0", flush); end
    checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL rst_mid_cnt: got %0d want 0", stall_cnt); end
    @(negedge clk) rst_n = 1'b1;
    checks++;
    if ({hazard, stall_cnt} !== 9'd0) begin
      failures++; $display("FAIL post_rst_empty: got hz=%b cnt=%0d want hz=0 cnt=0", hazard, stall_cnt);
    end
    @(negedge clk);
    checks++;
    if ({hazard, stall_cnt} !== {1'b1, 8'd0}) begin
      failures++; $display("FAIL post_rst_issue: got hz=%b cnt=%0d want hz=1 cnt=0", hazard, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_two_src_r15();
    test_branch_flush();
    test_freeze();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
